// File: rtl/router_pkg.sv
// Shared widths, state encoding and header framing for the router packet source.
package router_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int LEN_W  = 6;

    // Destination port 3 does not exist on the router.
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        HEADER,
        PAYLOAD,
        PARITY,
        GAP
    } state_t;

    // The header byte carries the payload length above the destination address.
    function automatic logic [DATA_W-1:0] make_header(input logic [LEN_W-1:0]  len,
                                                      input logic [ADDR_W-1:0] addr);
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_pkt_buf.sv
// Payload store: one synchronous write port, one asynchronous read port.
// Contents are not reset; a packet always rewrites every byte it later reads.
module router_pkt_buf
    import router_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [LEN_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [LEN_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Capture a payload byte on each accepted write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_pkt_src.sv
// Packet source: buffers a full payload, then frames header, payload and
// parity onto the router input with no bubbles, honouring busy backpressure.
module router_pkt_src
    import router_pkg::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter int MAX_LEN    = 63
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              pl_valid,
    output logic              pl_ready,
    input  logic [DATA_W-1:0] pl_data,
    input  logic              busy,
    output logic              pkt_valid,
    output logic [DATA_W-1:0] pkt_data,
    output logic              src_active,
    output logic              tx_done,
    output logic              req_err
);

    // GAP lasts GAP_CYCLES cycles: the counter runs from GAP_CYCLES-1 down to 0.
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [DATA_W-1:0] parity;
    logic [LEN_W-1:0]  wr_cnt;
    logic [LEN_W-1:0]  rd_idx;
    logic [3:0]        gap_cnt;

    logic              req_fire;
    logic              req_bad;
    logic              pl_fire;
    logic              pl_last;
    logic              consume;
    logic              rd_last;
    logic [LEN_W-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_data;

    assign req_ready  = (state == IDLE);
    assign pl_ready   = (state == COLLECT);
    assign src_active = (state != IDLE);

    assign req_fire = req_valid && req_ready;
    assign req_bad  = (req_addr == ADDR_INVALID) || (req_len == '0);
    assign pl_fire  = pl_valid && pl_ready;
    assign pl_last  = pl_fire && (wr_cnt == len_q - 6'd1);
    assign consume  = !busy && ((state == HEADER) || (state == PAYLOAD) || (state == PARITY));
    assign rd_last  = (rd_idx == len_q - 6'd1);

    // The byte loaded while HEADER is on the wire is payload[0]; afterwards
    // the read port looks one ahead of the byte currently presented.
    assign rd_addr = (state == HEADER) ? '0 : rd_idx + 6'd1;

    router_pkt_buf #(
        .DEPTH(MAX_LEN + 1)
    ) u_buf (
        .clk     (clk),
        .wr_en   (pl_fire),
        .wr_addr (wr_cnt),
        .wr_data (pl_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: advance on handshakes in the client phases and on
    // consume in the transmit phases.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_fire && !req_bad) begin
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (pl_last) begin
                    state_nxt = HEADER;
                end
            end
            HEADER: begin
                if (consume) begin
                    state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (consume && rd_last) begin
                    state_nxt = PARITY;
                end
            end
            PARITY: begin
                if (consume) begin
                    state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_cnt == 4'd0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: request latch, parity accumulation, counters and the
    // registered router-facing outputs. Pulses default low every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q    <= '0;
            len_q     <= '0;
            parity    <= '0;
            wr_cnt    <= '0;
            rd_idx    <= '0;
            gap_cnt   <= '0;
            pkt_valid <= 1'b0;
            pkt_data  <= '0;
            tx_done   <= 1'b0;
            req_err   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            req_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        if (req_bad) begin
                            req_err <= 1'b1;
                        end else begin
                            addr_q <= req_addr;
                            len_q  <= req_len;
                            parity <= make_header(req_len, req_addr);
                            wr_cnt <= '0;
                        end
                    end
                end
                COLLECT: begin
                    if (pl_fire) begin
                        parity <= parity ^ pl_data;
                        wr_cnt <= wr_cnt + 6'd1;
                        if (pl_last) begin
                            pkt_valid <= 1'b1;
                            pkt_data  <= make_header(len_q, addr_q);
                            rd_idx    <= '0;
                        end
                    end
                end
                HEADER: begin
                    if (consume) begin
                        pkt_data <= rd_data;
                    end
                end
                PAYLOAD: begin
                    if (consume) begin
                        if (rd_last) begin
                            pkt_valid <= 1'b0;
                            pkt_data  <= parity;
                        end else begin
                            rd_idx   <= rd_idx + 6'd1;
                            pkt_data <= rd_data;
                        end
                    end
                end
                PARITY: begin
                    if (consume) begin
                        pkt_data <= '0;
                        tx_done  <= 1'b1;
                        gap_cnt  <= GAP_LOAD;
                    end
                end
                GAP: begin
                    if (gap_cnt != 4'd0) begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_src.sv
`timescale 1ns/1ps
module tb_router_pkt_src;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_addr = '0;
    logic [5:0] req_len = '0;
    logic       pl_valid = 1'b0;
    logic       pl_ready;
    logic [7:0] pl_data = '0;
    logic       busy = 1'b0;
    logic       pkt_valid;
    logic [7:0] pkt_data;
    logic       src_active;
    logic       tx_done;
    logic       req_err;

    bq_t exp_q;
    int  n_checks = 0;
    int  n_pass = 0;
    int  busy_mode = 0;   // 0: held low, 1: random, 2: driven by the stimulus

    always #5 clk = ~clk;

    router_pkt_src #(.GAP_CYCLES(2), .MAX_LEN(63)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .pl_valid   (pl_valid),
        .pl_ready   (pl_ready),
        .pl_data    (pl_data),
        .busy       (busy),
        .pkt_valid  (pkt_valid),
        .pkt_data   (pkt_data),
        .src_active (src_active),
        .tx_done    (tx_done),
        .req_err    (req_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: condition not reached at %0t", name, $time);
    endtask

    // Reference: the wire sequence of one packet is the header, the payload
    // in order, then the XOR of everything before it.
    function automatic bq_t model_pkt(input logic [1:0] a, input logic [5:0] l, input bq_t pl);
        bq_t q;
        logic [7:0] par;
        par = {l, a};
        q.push_back(par);
        foreach (pl[i]) begin
            q.push_back(pl[i]);
            par = par ^ pl[i];
        end
        q.push_back(par);
        return q;
    endfunction

    function automatic bq_t rand_payload(input int l);
        bq_t q;
        for (int i = 0; i < l; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // Busy driver, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (busy_mode == 1) busy = ($urandom_range(3) == 0);
            else if (busy_mode == 0) busy = 1'b0;
        end
    end

    // Monitor: every consumed byte is popped from the scoreboard and compared.
    initial begin
        logic seen_valid;
        logic done_pend;
        logic hold;
        logic [7:0] hold_d;
        logic [7:0] e;
        seen_valid = 0; done_pend = 0; hold = 0; hold_d = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                seen_valid = 0; done_pend = 0; hold = 0;
            end else begin
                if (tx_done || done_pend) chk("tx_done_pulse", tx_done, done_pend);
                done_pend = 0;
                if (hold) begin
                    chk("stall_hold_valid", pkt_valid, 1);
                    chk("stall_hold_data", pkt_data, hold_d);
                end
                hold   = pkt_valid && busy;
                hold_d = pkt_data;
                if (pkt_valid) begin
                    if (!busy) begin
                        if (exp_q.size() == 0) fail_now("unexpected_pkt_byte");
                        else begin
                            e = exp_q.pop_front();
                            chk("pkt_byte", pkt_data, e);
                        end
                    end
                    seen_valid = 1;
                end else if (seen_valid && !busy) begin
                    if (exp_q.size() == 0) fail_now("unexpected_parity");
                    else begin
                        e = exp_q.pop_front();
                        chk("parity_byte", pkt_data, e);
                    end
                    seen_valid = 0;
                    done_pend  = 1;
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic do_req(input logic [1:0] a, input logic [5:0] l);
        logic r;
        r = 0;
        req_valid = 1; req_addr = a; req_len = l;
        for (int n = 0; n < 400 && !r; n++) begin
            @(negedge clk);
            r = req_ready;
            @(posedge clk);
        end
        #1;
        req_valid = 0;
        if (!r) fail_now("req_handshake_timeout");
    endtask

    // mode 0: back-to-back, 1: pl_valid every other cycle, 2: random gaps.
    task automatic send_payload(input bq_t pl, input int mode);
        logic r;
        foreach (pl[i]) begin
            if (i > 0 && (mode == 1 || (mode == 2 && $urandom_range(2) == 0))) begin
                pl_valid = 0;
                @(posedge clk);
                #1;
            end
            pl_valid = 1; pl_data = pl[i]; r = 0;
            for (int n = 0; n < 50 && !r; n++) begin
                @(negedge clk);
                r = pl_ready;
                chk("no_pkt_valid_while_collecting", pkt_valid, 0);
                @(posedge clk);
            end
            #1;
            if (!r) fail_now("payload_handshake_timeout");
        end
        pl_valid = 0;
    endtask

    task automatic send_pkt(input logic [1:0] a, input logic [5:0] l, input bq_t pl, input int mode);
        bq_t m;
        m = model_pkt(a, l, pl);
        foreach (m[i]) exp_q.push_back(m[i]);
        do_req(a, l);
        send_payload(pl, mode);
    endtask

    // With busy low: header on the next cycle, then len+1 contiguous valid cycles.
    task automatic measure_run(input int l, input logic [7:0] hdr);
        int cnt;
        @(negedge clk);
        chk("header_next_cycle", pkt_valid, 1);
        chk("header_byte", pkt_data, hdr);
        cnt = 0;
        while (pkt_valid && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        chk("valid_run_length", cnt, l + 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        bq_t pl;
        logic [1:0] a;
        logic [5:0] l;

        #2;
        chk("reset_pkt_valid", pkt_valid, 0);
        chk("reset_pkt_data", pkt_data, 0);
        chk("reset_src_active", src_active, 0);
        chk("reset_tx_done", tx_done, 0);
        chk("reset_req_err", req_err, 0);
        repeat (3) @(posedge clk);
        #2 reset = 0;
        @(posedge clk);
        #1;
        chk("req_ready_after_reset", req_ready, 1);
        chk("pl_ready_idle", pl_ready, 0);

        // Basic packet with known bytes.
        busy_mode = 0;
        pl = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_pkt(2'd0, 6'd5, pl, 0);
        measure_run(5, 8'h14);
        chk("basic_parity_value", pkt_data, 8'h05);
        @(negedge clk);
        chk("gap1_req_ready", req_ready, 0);
        @(negedge clk);
        chk("gap2_req_ready", req_ready, 0);
        @(negedge clk);
        chk("after_gap_req_ready", req_ready, 1);
        @(posedge clk);
        #1;

        // Stall on the first payload byte.
        busy_mode = 2;
        busy = 0;
        send_pkt(2'd1, 6'd20, rand_payload(20), 0);
        @(negedge clk);
        chk("stall_header", pkt_data, 8'h51);
        @(posedge clk);
        #1 busy = 1;
        repeat (3) @(posedge clk);
        #1 busy = 0;
        wait_idle();

        // Invalid requests.
        busy_mode = 0;
        do_req(2'd3, 6'd4);
        chk("bad_addr_req_err", req_err, 1);
        chk("bad_addr_pl_ready", pl_ready, 0);
        chk("bad_addr_req_ready", req_ready, 1);
        chk("bad_addr_pkt_valid", pkt_valid, 0);
        @(posedge clk);
        #1;
        chk("req_err_one_cycle", req_err, 0);
        do_req(2'd0, 6'd0);
        chk("zero_len_req_err", req_err, 1);
        chk("zero_len_pl_ready", pl_ready, 0);
        chk("zero_len_req_ready", req_ready, 1);
        @(posedge clk);
        #1;
        chk("req_err_one_cycle2", req_err, 0);

        // Throttled payload.
        send_pkt(2'd2, 6'd20, rand_payload(20), 1);
        measure_run(20, 8'h52);
        wait_idle();

        // Reset while the payload is on the wire.
        send_pkt(2'd1, 6'd12, rand_payload(12), 0);
        @(negedge clk);
        repeat (8) @(posedge clk);
        #3 reset = 1;
        #1;
        chk("async_reset_pkt_valid", pkt_valid, 0);
        chk("async_reset_pkt_data", pkt_data, 0);
        chk("async_reset_src_active", src_active, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2 reset = 0;
        @(posedge clk);
        #1;
        send_pkt(2'd2, 6'd3, rand_payload(3), 0);
        measure_run(3, 8'h0E);
        wait_idle();

        // Maximum length.
        send_pkt(2'd2, 6'd63, rand_payload(63), 0);
        measure_run(63, 8'hFE);
        wait_idle();

        // Randomized traffic with random backpressure.
        busy_mode = 1;
        for (int k = 0; k < 14; k++) begin
            if ($urandom_range(4) == 0) begin
                if ($urandom_range(1) == 0) begin
                    a = 2'd3; l = 6'($urandom_range(63));
                end else begin
                    a = 2'($urandom_range(2)); l = 6'd0;
                end
                do_req(a, l);
                chk("rand_req_err", req_err, 1);
            end else begin
                a = 2'($urandom_range(2));
                l = 6'($urandom_range(63, 1));
                send_pkt(a, l, rand_payload(int'(l)), $urandom_range(2));
            end
        end
        wait_idle();
        busy_mode = 0;
        repeat (4) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
